// File: rtl/exmem_pkg.sv
// exmem_pkg: shared constants for the EX/MEM datapath slice.
// alu_op classes, alu_control codes, R-type funct values, memory depth.
package exmem_pkg;

  localparam int DEPTH_WORDS_DEF = 64;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_RTYPE = 3'b010;
  localparam logic [2:0] ALU_OP_AND   = 3'b011;
  localparam logic [2:0] ALU_OP_OR    = 3'b100;
  localparam logic [2:0] ALU_OP_SLT   = 3'b101;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_INV = 4'b1111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] result;
    logic        zero;
  } ex_res_t;

  function automatic logic is_zero(input logic [31:0] v);
    return (v == 32'd0);
  endfunction

endpackage

// File: rtl/exmem_alu_dec.sv
// exmem_alu_dec: alu_op/funct to alu_control decoder, combinational.
// SLT decode is present only when EXMEM_SLT_EN is defined.
module exmem_alu_dec
  import exmem_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);

  logic [3:0] r_ctl;

  // R-type: operation comes from the funct field
  always_comb begin
    r_ctl = ALU_INV;
    unique case (funct)
      FUNCT_ADD: r_ctl = ALU_ADD;
      FUNCT_SUB: r_ctl = ALU_SUB;
      FUNCT_AND: r_ctl = ALU_AND;
      FUNCT_OR:  r_ctl = ALU_OR;
      FUNCT_NOR: r_ctl = ALU_NOR;
`ifdef EXMEM_SLT_EN
      FUNCT_SLT: r_ctl = ALU_SLT;
`endif
      default:   r_ctl = ALU_INV;
    endcase
  end

  // Operation class select; unlisted classes fall back to ADD
  always_comb begin
    alu_control = ALU_ADD;
    unique case (1'b1)
      (alu_op == ALU_OP_SUB):   alu_control = ALU_SUB;
      (alu_op == ALU_OP_RTYPE): alu_control = r_ctl;
      (alu_op == ALU_OP_AND):   alu_control = ALU_AND;
      (alu_op == ALU_OP_OR):    alu_control = ALU_OR;
`ifdef EXMEM_SLT_EN
      (alu_op == ALU_OP_SLT):   alu_control = ALU_SLT;
`else
      (alu_op == ALU_OP_SLT):   alu_control = ALU_INV;
`endif
      default:                  alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/exmem_datapath.sv
// exmem_datapath: EX-stage ALU plus MEM-stage word-addressed data memory.
// Define EXMEM_SLT_EN to enable the signed set-less-than operation.
module exmem_datapath
  import exmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        zero,
  input  logic [31:0] mem_addr,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] read_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  ex_res_t ex;

  exmem_alu_dec u_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (ex.ctl)
  );

  // ALU: wrapping add/sub, bitwise ops, optional signed compare
  always_comb begin
    ex.result = 32'd0;
    unique case (ex.ctl)
      ALU_AND: ex.result = a & b;
      ALU_OR:  ex.result = a | b;
      ALU_ADD: ex.result = a + b;
      ALU_SUB: ex.result = a - b;
      ALU_NOR: ex.result = ~(a | b);
`ifdef EXMEM_SLT_EN
      ALU_SLT: ex.result = {31'd0, $signed(a) < $signed(b)};
`endif
      default: ex.result = 32'd0;
    endcase
  end

  assign ex.zero     = is_zero(ex.result);
  assign alu_control = ex.ctl;
  assign alu_result  = ex.result;
  assign zero        = ex.zero;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          unused_addr;

  // byte offset and high bits are dropped: aligned, wrapping access
  assign idx         = mem_addr[AW+1:2];
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // Array update: reset wins over a same-edge store
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem[i] <= 32'd0;
    end else if (mem_write) begin
      mem[idx] <= write_data;
    end
  end

  assign read_data = mem_read ? mem[idx] : 32'd0;

endmodule

// File: tb/tb_exmem_datapath.sv
// tb_exmem_datapath: vector table, directed memory sequences and
// randomized checks against a behavioural model of the datapath.
module tb_exmem_datapath;

  localparam int D = 64;
`ifdef EXMEM_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_addr = '0;
  logic [31:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] read_data;

  int vectors = 0;
  int miscompares = 0;

  exmem_datapath #(.DEPTH_WORDS(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_op      (alu_op),
    .funct       (funct),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .zero        (zero),
    .mem_addr    (mem_addr),
    .write_data  (write_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .read_data   (read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] ref_mem [D];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctl(input logic [2:0] op,
                                         input logic [5:0] fn);
    if (op == 3'd2) begin
      case (fn)
        6'd32: return 4'b0010;
        6'd34: return 4'b0110;
        6'd36: return 4'b0000;
        6'd37: return 4'b0001;
        6'd39: return 4'b1100;
        6'd42: return SLT_EN ? 4'b0111 : 4'b1111;
        default: return 4'b1111;
      endcase
    end
    if (op == 3'd1) return 4'b0110;
    if (op == 3'd3) return 4'b0000;
    if (op == 3'd4) return 4'b0001;
    if (op == 3'd5) return SLT_EN ? 4'b0111 : 4'b1111;
    return 4'b0010;
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] c,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    int signed sx, sy;
    sx = x;
    sy = y;
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
      4'b0110: return 32'((64'h1_0000_0000 + 64'(x) - 64'(y))
                          % 64'h1_0000_0000);
      4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
      4'b1100: return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 4) % D);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_check(input string name, input logic [31:0] addr,
                           input logic [31:0] exp);
    mem_addr = addr;
    mem_read = 1'b1;
    #1;
    chk(name, read_data, exp);
  endtask

  initial begin
    logic [31:0] exp_slt1, exp_z1;
    logic [3:0]  slt_ctl;
    logic [3:0]  ec;
    logic [31:0] er;
    logic [5:0]  fsel [8];
    int          ix;

    slt_ctl  = SLT_EN ? 4'b0111 : 4'b1111;
    exp_slt1 = SLT_EN ? 32'd1 : 32'd0;
    exp_z1   = SLT_EN ? 32'd0 : 32'd1;

    tbl.push_back('{3'd2, 6'd32, 32'd5, 32'd5, 4'b0010, 32'd10, 1'b0});
    tbl.push_back('{3'd1, 6'd0, 32'd7, 32'd7, 4'b0110, 32'd0, 1'b1});
    tbl.push_back('{3'd2, 6'd36, 32'hF0F0_0000, 32'hFF00_FF00,
                    4'b0000, 32'hF000_0000, 1'b0});
    tbl.push_back('{3'd2, 6'd37, 32'hF0F0_0000, 32'hFF00_FF00,
                    4'b0001, 32'hFFF0_FF00, 1'b0});
    tbl.push_back('{3'd2, 6'd39, 32'hF0F0_0000, 32'hFF00_FF00,
                    4'b1100, 32'h000F_00FF, 1'b0});
    tbl.push_back('{3'd2, 6'd0, 32'd5, 32'd5, 4'b1111, 32'd0, 1'b1});
    tbl.push_back('{3'd5, 6'd0, 32'hFFFF_FFFF, 32'd1,
                    slt_ctl, exp_slt1, exp_z1[0]});
    tbl.push_back('{3'd5, 6'd0, 32'd1, 32'hFFFF_FFFF,
                    slt_ctl, 32'd0, 1'b1});
    tbl.push_back('{3'd2, 6'd42, 32'hFFFF_FFFF, 32'd1,
                    slt_ctl, exp_slt1, exp_z1[0]});
    tbl.push_back('{3'd0, 6'd0, 32'hFFFF_FFFF, 32'd1,
                    4'b0010, 32'd0, 1'b1});
    tbl.push_back('{3'd1, 6'd0, 32'd0, 32'd1,
                    4'b0110, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{3'd3, 6'd0, 32'h0000_FFFF, 32'h00FF_00FF,
                    4'b0000, 32'h0000_00FF, 1'b0});
    tbl.push_back('{3'd4, 6'd0, 32'h1200_0000, 32'h0000_0034,
                    4'b0001, 32'h1200_0034, 1'b0});
    tbl.push_back('{3'd6, 6'd42, 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0});
    tbl.push_back('{3'd7, 6'd34, 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0});
    tbl.push_back('{3'd2, 6'd34, 32'd3, 32'd3, 4'b0110, 32'd0, 1'b1});

    // reset: read_data low when not reading, memory cleared after
    tick();
    #1;
    chk("rst_rd_off", read_data, 32'd0);
    tick();
    rst = 1'b0;
    mem_check("rst_w0", 32'd0, 32'd0);
    mem_check("rst_w63", 32'd252, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      alu_op = tbl[i].op;
      funct  = tbl[i].fn;
      a      = tbl[i].va;
      b      = tbl[i].vb;
      #1;
      chk($sformatf("tbl%0d_ctl", i), 32'(alu_control), 32'(tbl[i].ctl));
      chk($sformatf("tbl%0d_res", i), alu_result, tbl[i].res);
      chk($sformatf("tbl%0d_zero", i), 32'(zero), 32'(tbl[i].z));
    end

    // store then load, offset and wrap aliases
    mem_addr   = 32'd20;
    write_data = 32'd5;
    mem_write  = 1'b1;
    mem_read   = 1'b1;
    #1;
    chk("st_same_cycle", read_data, 32'd0);
    tick();
    mem_write = 1'b0;
    mem_check("ld_20", 32'd20, 32'd5);
    mem_check("ld_23", 32'd23, 32'd5);
    mem_check("ld_wrap", 32'd20 + 32'(4 * D), 32'd5);
    mem_read = 1'b0;
    #1;
    chk("ld_rd_off", read_data, 32'd0);

    // reset discards a same-edge store and clears prior data
    mem_addr   = 32'd8;
    write_data = 32'hDEAD_BEEF;
    mem_write  = 1'b1;
    tick();
    mem_write = 1'b0;
    mem_check("ld_8", 32'd8, 32'hDEAD_BEEF);
    rst        = 1'b1;
    mem_addr   = 32'd12;
    write_data = 32'h1234_5678;
    mem_write  = 1'b1;
    mem_read   = 1'b0;
    tick();
    rst       = 1'b0;
    mem_write = 1'b0;
    mem_check("rst_8", 32'd8, 32'd0);
    mem_check("rst_12", 32'd12, 32'd0);
    mem_check("rst_20", 32'd20, 32'd0);

    // randomized ALU against the arithmetic model
    fsel = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd1};
    for (int i = 0; i < 300; i++) begin
      alu_op = 3'($urandom_range(0, 7));
      ix     = int'($urandom_range(0, 8));
      funct  = (ix == 8) ? 6'($urandom) : fsel[ix];
      a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                           : $urandom;
      b      = ($urandom_range(0, 3) == 0) ? a : $urandom;
      #1;
      ec = ref_ctl(alu_op, funct);
      er = ref_res(ec, a, b);
      chk("rnd_ctl", 32'(alu_control), 32'(ec));
      chk("rnd_res", alu_result, er);
      chk("rnd_zero", 32'(zero), 32'(er == 32'd0));
    end

    // randomized memory traffic against an array model
    for (int i = 0; i < D; i++) ref_mem[i] = 32'd0;
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      mem_write  = $urandom_range(0, 1) == 1;
      mem_read   = $urandom_range(0, 3) != 0;
      mem_addr   = ($urandom_range(0, 1) == 1) ? $urandom
                                               : 32'($urandom_range(0, 63));
      write_data = $urandom;
      #1;
      chk("rnd_rd", read_data,
          mem_read ? ref_mem[widx(mem_addr)] : 32'd0);
      tick();
      if (rst) begin
        for (int k = 0; k < D; k++) ref_mem[k] = 32'd0;
      end else if (mem_write) begin
        ref_mem[widx(mem_addr)] = write_data;
      end
    end
    rst       = 1'b0;
    mem_write = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
